// File: rtl/interleaver_bank_scheduler.sv
// rtl/interleaver_bank_scheduler.sv - ping-pong bank sequencer for the 802.11a block (de)interleaver buffer
// Fills one bank row-major while the other drains in permuted order; one bit per cycle each side.
module interleaver_bank_scheduler #(
  parameter int N_CBPS = 48,
  parameter int N_COLS = 16,
  localparam int N_ROWS = N_CBPS / N_COLS,
  localparam int AW = $clog2(N_CBPS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          mode_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic          wr_en_o,
  output logic          wr_bank_o,
  output logic [AW-1:0] wr_addr_o,
  output logic          rd_en_o,
  output logic          rd_bank_o,
  output logic [AW-1:0] rd_addr_o,
  input  logic          out_ready_i,
  output logic          out_valid_o,
  output logic          out_first_o,
  output logic          out_last_o
);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;

  localparam logic [AW-1:0] LAST    = AW'(N_CBPS - 1);
  localparam logic [AW-1:0] ROWS_W  = AW'(N_ROWS);
  localparam logic [AW-1:0] COLS_W  = AW'(N_COLS);
  localparam logic [AW-1:0] ROWS_M1 = AW'(N_ROWS - 1);
  localparam logic [AW-1:0] COLS_M1 = AW'(N_COLS - 1);

  bank_state_e   state_q [2];
  logic [1:0]    mode_q;
  logic          wr_bank_q, rd_bank_q;
  logic [AW-1:0] wr_cnt_q, rd_cnt_q;
  // j split as (j % N_ROWS, j / N_ROWS) and (j % N_COLS, j / N_COLS), stepped incrementally
  logic [AW-1:0] ilv_mod_q, ilv_div_q, dil_mod_q, dil_div_q;
  logic          out_valid_q, out_first_q, out_last_q;

  bank_state_e   wr_state, rd_state;
  logic          wr_en, rd_en, wr_last, rd_last;

  assign wr_state   = state_q[wr_bank_q];
  assign rd_state   = state_q[rd_bank_q];
  assign in_ready_o = !rst_i && (wr_state == EMPTY || wr_state == FILLING);
  assign wr_en      = in_valid_i && in_ready_o;
  assign rd_en      = (rd_state == FULL || rd_state == DRAINING) && (!out_valid_q || out_ready_i);
  assign wr_last    = (wr_cnt_q == LAST);
  assign rd_last    = (rd_cnt_q == LAST);

  assign wr_en_o     = wr_en;
  assign wr_bank_o   = wr_bank_q;
  assign wr_addr_o   = wr_cnt_q;
  assign rd_en_o     = rd_en;
  assign rd_bank_o   = rd_bank_q;
  assign rd_addr_o   = mode_q[rd_bank_q] ? (dil_mod_q * ROWS_W + dil_div_q)
                                         : (ilv_mod_q * COLS_W + ilv_div_q);
  assign out_valid_o = out_valid_q;
  assign out_first_o = out_first_q;
  assign out_last_o  = out_last_q;

  // Banks being written and read are never in the same state class, so the two
  // state_q updates below can never target the same element in one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q[0]  <= EMPTY;
      state_q[1]  <= EMPTY;
      mode_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      ilv_mod_q   <= '0;
      ilv_div_q   <= '0;
      dil_mod_q   <= '0;
      dil_div_q   <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      if (wr_en) begin
        if (wr_state == EMPTY) mode_q[wr_bank_q] <= mode_i;
        if (wr_last) begin
          state_q[wr_bank_q] <= FULL;
          wr_cnt_q           <= '0;
          wr_bank_q          <= ~wr_bank_q;
        end else begin
          state_q[wr_bank_q] <= FILLING;
          wr_cnt_q           <= wr_cnt_q + 1'b1;
        end
      end

      if (rd_en) begin
        if (rd_last) begin
          state_q[rd_bank_q] <= EMPTY;
          rd_cnt_q           <= '0;
          rd_bank_q          <= ~rd_bank_q;
          ilv_mod_q          <= '0;
          ilv_div_q          <= '0;
          dil_mod_q          <= '0;
          dil_div_q          <= '0;
        end else begin
          state_q[rd_bank_q] <= DRAINING;
          rd_cnt_q           <= rd_cnt_q + 1'b1;
          if (ilv_mod_q == ROWS_M1) begin
            ilv_mod_q <= '0;
            ilv_div_q <= ilv_div_q + 1'b1;
          end else begin
            ilv_mod_q <= ilv_mod_q + 1'b1;
          end
          if (dil_mod_q == COLS_M1) begin
            dil_mod_q <= '0;
            dil_div_q <= dil_div_q + 1'b1;
          end else begin
            dil_mod_q <= dil_mod_q + 1'b1;
          end
        end
        out_valid_q <= 1'b1;
        out_first_q <= (rd_cnt_q == '0);
        out_last_q  <= rd_last;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
        out_first_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_interleaver_bank_scheduler.sv
// tb/tb_interleaver_bank_scheduler.sv - scoreboard bench for interleaver_bank_scheduler
// Bench RAM stores each bit's global sequence number so output order exposes both address streams.
module tb_interleaver_bank_scheduler;

  logic       clk, rst, mode, in_valid, out_ready;
  logic       in_ready, wr_en, wr_bank, rd_en, rd_bank, out_valid, out_first, out_last;
  logic [5:0] wr_addr, rd_addr;

  interleaver_bank_scheduler #(.N_CBPS(48), .N_COLS(16)) dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .wr_en_o(wr_en), .wr_bank_o(wr_bank), .wr_addr_o(wr_addr),
    .rd_en_o(rd_en), .rd_bank_o(rd_bank), .rd_addr_o(rd_addr),
    .out_ready_i(out_ready), .out_valid_o(out_valid), .out_first_o(out_first), .out_last_o(out_last)
  );

  typedef struct {
    int seq;
    bit first;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   ram [2][64];
  int   rd_data = 0;
  int   cyc = 0;
  int   cur_seq = 0, seq_ctr = 0;
  int   n_cmp = 0, n_err = 0;
  int   stalls = 0, bubbles = 0;
  int   last_wr_cyc = 0;
  bit   lat_arm = 0, bubble_mon = 0, prev_ov = 0, hold_pending = 0;
  int   hold_data = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (wr_en) ram[wr_bank][wr_addr] <= cur_seq;
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_bank][rd_addr];

  task automatic check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Hand-derived permutations for 48 bits, 3 rows x 16 columns
  function automatic int perm(input bit m, input int j);
    if (!m) return (j % 3) * 16 + j / 3;
    return (j % 16) * 3 + j / 16;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 0;
      prev_ov      = 0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_data", rd_data, hold_data);
        hold_pending = 0;
      end
      if (out_valid && !out_ready) begin
        hold_pending = 1;
        hold_data    = rd_data;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got seq %0d expected no output", rd_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_seq", rd_data, e.seq);
          check("out_first", int'(out_first), int'(e.first));
          check("out_last", int'(out_last), int'(e.last));
          if (lat_arm && out_first) begin
            check("first_latency", cyc - last_wr_cyc, 2);
            lat_arm = 0;
          end
        end
      end
      if (bubble_mon && prev_ov && !out_valid && exp_q.size() != 0) bubbles++;
      prev_ov = out_valid;
    end
  end

  task automatic send_sym(input bit m, input int toggle_at, input int nbits);
    int base;
    base = seq_ctr;
    if (nbits == 48)
      for (int j = 0; j < 48; j++)
        exp_q.push_back('{seq: base + perm(m, j), first: (j == 0), last: (j == 47)});
    for (int i = 0; i < nbits; i++) begin
      int waited;
      mode     = (toggle_at >= 0 && i >= toggle_at) ? ~m : m;
      cur_seq  = seq_ctr;
      in_valid = 1'b1;
      waited   = 0;
      while (!in_ready) begin
        stalls++;
        waited++;
        if (waited > 2000) begin
          $display("FAIL in_ready_timeout: got in_ready 0 for %0d cycles expected 1", waited);
          $fatal(1, "driver stuck");
        end
        @(posedge clk); #1;
      end
      last_wr_cyc = cyc;
      @(posedge clk); #1;
      seq_ctr++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("drain_queue_empty", exp_q.size(), 0);
    check("idle_out_valid", int'(out_valid), 0);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_first", int'(out_first), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_wr_bank", int'(wr_bank), 0);
    check("rst_rd_bank", int'(rd_bank), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    // 1: interleave, latency of first output bit
    send_sym(1'b0, -1, 48);
    lat_arm = 1;
    wait_drain();
    check("latency_seen", int'(lat_arm), 0);

    // 2: deinterleave
    send_sym(1'b1, -1, 48);
    wait_drain();

    // 3: ten symbols back to back
    stalls = 0; bubbles = 0; bubble_mon = 1;
    for (int k = 0; k < 10; k++) send_sym(k[0], -1, 48);
    check("stream_in_ready_stalls", stalls, 0);
    wait_drain();
    bubble_mon = 0;
    check("stream_bubbles", bubbles, 0);

    // 4: downstream stall for 200 cycles mid-drain
    stalls = 0;
    fork
      begin
        send_sym(1'b0, -1, 48);
        send_sym(1'b1, -1, 48);
        send_sym(1'b0, -1, 48);
      end
      begin
        repeat (60) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (200) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    check("stall_in_ready_dropped", int'(stalls > 0), 1);
    wait_drain();

    // 5: mode toggled mid-symbol only affects the next symbol
    send_sym(1'b0, 20, 48);
    send_sym(1'b1, -1, 48);
    wait_drain();

    // 6: reset mid-symbol while the other bank drains
    send_sym(1'b0, -1, 48);
    send_sym(1'b1, -1, 30);
    check("pre_rst_rd_active", int'(out_valid), 1);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", int'(in_ready), 0);
    check("midrst_wr_en", int'(wr_en), 0);
    check("midrst_rd_en", int'(rd_en), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_first", int'(out_first), 0);
    check("midrst_out_last", int'(out_last), 0);
    check("midrst_wr_addr", int'(wr_addr), 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    send_sym(1'b0, -1, 48);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
